sdpram_arbiter: RTL and testbench

Two-client round-robin arbiter and sequencer for the simple dual-port RAM. It shares the RAM write port (A) between two write requesters and the read port (B) between two read requesters. Each port has its own fair arbitration. Read data is returned to the issuing requester with a tagged valid pulse, and a same-address read is held back one cycle behind a same-cycle write, so every granted read observes all previously granted writes. The block sits between the client logic and the `sdpram_if` signals of the RAM instance.

---
 rtl/sdpram_arbiter.sv | 143 ++++++++++++++
 tb/tb_sdpram_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdpram_arbiter.sv
// ---------------------------------------------------------------------------
// sdpram_arbiter
//
// Two-client round-robin arbiter and sequencer for a simple dual-port RAM.
// The RAM write port (A) is shared between two writers and the read port (B)
// is shared between two readers, each port with its own fair pointer. Read
// data goes back to the issuing reader with a one-cycle tagged valid pulse.
// A read whose address matches the write granted in the same cycle (with a
// nonzero strobe) is held off, so every granted read sees all earlier writes.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   wr_req     write request per client
//   wr_addr    packed client write addresses (client i at [i*ADDR_WIDTH +:])
//   wr_data    packed client write data
//   wr_strb    packed client byte enables
//   wr_gnt     one-hot write grant (combinational)
//   rd_req     read request per client
//   rd_addr    packed client read addresses
//   rd_gnt     one-hot read grant (combinational)
//   rd_valid   one-hot, one cycle, marks the owner of rd_data
//   rd_data    read data (straight from doutb)
//   wena/addra/dina   RAM write port, zero when idle
//   renb/addrb        RAM read port, zero address when idle
//   doutb      RAM read data
// ---------------------------------------------------------------------------
module sdpram_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_DEPTH    = 1024,
  parameter int ADDR_WIDTH   = $clog2(MEM_DEPTH),
  parameter int STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              wr_req,
  input  logic [2*ADDR_WIDTH-1:0] wr_addr,
  input  logic [2*DATA_WIDTH-1:0] wr_data,
  input  logic [2*STRB_WIDTH-1:0] wr_strb,
  output logic [1:0]              wr_gnt,
  input  logic [1:0]              rd_req,
  input  logic [2*ADDR_WIDTH-1:0] rd_addr,
  output logic [1:0]              rd_gnt,
  output logic [1:0]              rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [STRB_WIDTH-1:0]   wena,
  output logic [ADDR_WIDTH-1:0]   addra,
  output logic [DATA_WIDTH-1:0]   dina,
  output logic                    renb,
  output logic [ADDR_WIDTH-1:0]   addrb,
  input  logic [DATA_WIDTH-1:0]   doutb
);

  // Two-way round robin: on contention the pointer names the winner,
  // otherwise the lone requester (or nobody) wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
    logic [1:0] gnt;
    gnt = req;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
    return gnt;
  endfunction

  logic                    wptr;
  logic                    rptr;
  logic [1:0]              wgnt;
  logic [1:0]              rgnt;
  logic [1:0]              rcand;
  logic                    wr_live;
  logic [ADDR_WIDTH-1:0]   rd_addr0;
  logic [ADDR_WIDTH-1:0]   rd_addr1;
  logic [READ_LATENCY-1:0] vld_p;
  logic [READ_LATENCY-1:0] idx_p;

  assign rd_addr0 = rd_addr[0          +: ADDR_WIDTH];
  assign rd_addr1 = rd_addr[ADDR_WIDTH +: ADDR_WIDTH];

  // Write port selection
  assign wgnt   = rr_pick(wr_req, wptr);
  assign wr_gnt = wgnt;

  always_comb begin
    wena  = '0;
    addra = '0;
    dina  = '0;
    if (wgnt[1]) begin
      wena  = wr_strb[STRB_WIDTH +: STRB_WIDTH];
      addra = wr_addr[ADDR_WIDTH +: ADDR_WIDTH];
      dina  = wr_data[DATA_WIDTH +: DATA_WIDTH];
    end else if (wgnt[0]) begin
      wena  = wr_strb[0 +: STRB_WIDTH];
      addra = wr_addr[0 +: ADDR_WIDTH];
      dina  = wr_data[0 +: DATA_WIDTH];
    end
  end

  // A zero-strobe write occupies the slot but changes nothing, so it must
  // not hold back a read of the same word.
  assign wr_live = |wena;

  assign rcand[0] = rd_req[0] & ~(wr_live & (rd_addr0 == addra));
  assign rcand[1] = rd_req[1] & ~(wr_live & (rd_addr1 == addra));

  // Read port selection among non-colliding readers
  assign rgnt   = rr_pick(rcand, rptr);
  assign rd_gnt = rgnt;
  assign renb   = |rgnt;
  assign addrb  = rgnt[1] ? rd_addr1 : (rgnt[0] ? rd_addr0 : '0);

  // Fairness pointers: after a grant the other client gets priority.
  // A blocked reader never receives a grant, so rptr stays put for it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
    end else begin
      if (|wgnt) wptr <= wgnt[0];
      if (|rgnt) rptr <= rgnt[0];
    end
  end

  // Tag pipeline stage 0 .. READ_LATENCY-1: valid bits (reset clears
  // in-flight reads so none report after reset release)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= renb;
      for (int s = 1; s < READ_LATENCY; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  // Tag pipeline stage 0 .. READ_LATENCY-1: client index, qualified by vld_p
  always_ff @(posedge clk) begin
    idx_p[0] <= rgnt[1];
    for (int s = 1; s < READ_LATENCY; s++) idx_p[s] <= idx_p[s-1];
  end

  assign rd_valid[0] = vld_p[READ_LATENCY-1] & ~idx_p[READ_LATENCY-1];
  assign rd_valid[1] = vld_p[READ_LATENCY-1] &  idx_p[READ_LATENCY-1];
  assign rd_data     = doutb;

endmodule

// File: tb/tb_sdpram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdpram_arbiter
//
// Drives two arbiter instances (read latency 1 and 3) with identical client
// traffic, each attached to its own behavioural RAM. A reference model of
// the arbitration rules, memory contents and response timing predicts every
// output each cycle.
// ---------------------------------------------------------------------------
module tb_sdpram_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]    wr_req;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic [2*SW-1:0] wr_strb;
  logic [1:0]    rd_req;
  logic [2*AW-1:0] rd_addr;

  logic [1:0]    wr_gnt1, rd_gnt1, rd_valid1;
  logic [DW-1:0] rd_data1, dina1, doutb1;
  logic [SW-1:0] wena1;
  logic [AW-1:0] addra1, addrb1;
  logic          renb1;

  logic [1:0]    wr_gnt3, rd_gnt3, rd_valid3;
  logic [DW-1:0] rd_data3, dina3, doutb3;
  logic [SW-1:0] wena3;
  logic [AW-1:0] addra3, addrb3;
  logic          renb3;

  sdpram_arbiter #(.DATA_WIDTH(DW), .MEM_DEPTH(1024), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_gnt(wr_gnt1),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt1),
    .rd_valid(rd_valid1), .rd_data(rd_data1),
    .wena(wena1), .addra(addra1), .dina(dina1),
    .renb(renb1), .addrb(addrb1), .doutb(doutb1)
  );

  sdpram_arbiter #(.DATA_WIDTH(DW), .MEM_DEPTH(1024), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_gnt(wr_gnt3),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt3),
    .rd_valid(rd_valid3), .rd_data(rd_data3),
    .wena(wena3), .addra(addra3), .dina(dina3),
    .renb(renb3), .addrb(addrb3), .doutb(doutb3)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < SW; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Behavioural RAMs: read captured at the issue edge, then delayed.
  logic [DW-1:0] mem1 [1024];
  logic [DW-1:0] mem3 [1024];
  logic [DW-1:0] pipe1;
  logic [DW-1:0] pipe3 [3];
  assign doutb1 = pipe1;
  assign doutb3 = pipe3[2];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = '0;
      mem3[i] = '0;
    end
    pipe1 = '0;
    for (int i = 0; i < 3; i++) pipe3[i] = '0;
    forever begin
      @(posedge clk);
      if (renb1) pipe1 = mem1[addrb1];
      pipe3[2] = pipe3[1];
      pipe3[1] = pipe3[0];
      if (renb3) pipe3[0] = mem3[addrb3];
      if (|wena1) mem1[addra1] = merge(mem1[addra1], dina1, wena1);
      if (|wena3) mem3[addra3] = merge(mem3[addra3], dina3, wena3);
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [1024];
  logic          m_wptr, m_rptr;
  int            cyc;
  logic          exp_v1 [8];
  logic          exp_c1 [8];
  logic [DW-1:0] exp_d1 [8];
  logic          exp_v3 [8];
  logic          exp_c3 [8];
  logic [DW-1:0] exp_d3 [8];
  logic [1:0]    last_wg, last_rg;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Priority client wins on contention; otherwise whoever asks.
  function automatic logic [1:0] pick(input logic [1:0] req, input logic ptr);
    if (req == 2'b11) return ptr ? 2'b10 : 2'b01;
    return req;
  endfunction

  task automatic model_reset();
    m_wptr  = 1'b0;
    m_rptr  = 1'b0;
    last_wg = 2'b00;
    last_rg = 2'b00;
    for (int i = 0; i < 8; i++) begin
      exp_v1[i] = 1'b0; exp_c1[i] = 1'b0; exp_d1[i] = '0;
      exp_v3[i] = 1'b0; exp_c3[i] = 1'b0; exp_d3[i] = '0;
    end
  endtask

  // One clock: check outputs mid-cycle against the model, advance the model
  // across the edge, then return just after the edge for new stimulus.
  task automatic step();
    logic [1:0]    eg_w, eg_r, cand, ev;
    logic [SW-1:0] ws;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    int            wi, ri, s;
    @(negedge clk);
    eg_w = pick(wr_req, m_wptr);
    wi   = (eg_w == 2'b10) ? 1 : 0;
    ws   = (eg_w != 2'b00) ? wr_strb[wi*SW +: SW] : '0;
    wa   = (eg_w != 2'b00) ? wr_addr[wi*AW +: AW] : '0;
    wd   = (eg_w != 2'b00) ? wr_data[wi*DW +: DW] : '0;
    for (int i = 0; i < 2; i++)
      cand[i] = rd_req[i] && !((ws != '0) && (rd_addr[i*AW +: AW] == wa));
    eg_r = pick(cand, m_rptr);
    ri   = (eg_r == 2'b10) ? 1 : 0;
    ra   = (eg_r != 2'b00) ? rd_addr[ri*AW +: AW] : '0;

    chk("wr_gnt1", 64'(wr_gnt1), 64'(eg_w));
    chk("wr_gnt3", 64'(wr_gnt3), 64'(eg_w));
    chk("rd_gnt1", 64'(rd_gnt1), 64'(eg_r));
    chk("rd_gnt3", 64'(rd_gnt3), 64'(eg_r));
    chk("wena",    64'(wena1),   64'(ws));
    chk("addra",   64'(addra1),  64'(wa));
    chk("dina",    64'(dina1),   64'(wd));
    chk("renb",    64'(renb1),   64'(eg_r != 2'b00));
    chk("addrb",   64'(addrb1),  64'(ra));

    s  = cyc % 8;
    ev = exp_v1[s] ? (exp_c1[s] ? 2'b10 : 2'b01) : 2'b00;
    chk("rd_valid1", 64'(rd_valid1), 64'(ev));
    if (exp_v1[s]) chk("rd_data1", 64'(rd_data1), 64'(exp_d1[s]));
    exp_v1[s] = 1'b0;
    ev = exp_v3[s] ? (exp_c3[s] ? 2'b10 : 2'b01) : 2'b00;
    chk("rd_valid3", 64'(rd_valid3), 64'(ev));
    if (exp_v3[s]) chk("rd_data3", 64'(rd_data3), 64'(exp_d3[s]));
    exp_v3[s] = 1'b0;

    if (eg_r != 2'b00) begin
      exp_v1[(cyc+1)%8] = 1'b1; exp_c1[(cyc+1)%8] = (ri == 1); exp_d1[(cyc+1)%8] = ref_mem[ra];
      exp_v3[(cyc+3)%8] = 1'b1; exp_c3[(cyc+3)%8] = (ri == 1); exp_d3[(cyc+3)%8] = ref_mem[ra];
      m_rptr = (eg_r == 2'b01);
    end
    if (eg_w != 2'b00) begin
      ref_mem[wa] = merge(ref_mem[wa], wd, ws);
      m_wptr = (eg_w == 2'b01);
    end
    last_wg = eg_w;
    last_rg = eg_r;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int c, input logic r, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [SW-1:0] st);
    wr_req[c]          = r;
    wr_addr[c*AW +: AW] = a;
    wr_data[c*DW +: DW] = d;
    wr_strb[c*SW +: SW] = st;
  endtask

  task automatic set_rd(input int c, input logic r, input logic [AW-1:0] a);
    rd_req[c]           = r;
    rd_addr[c*AW +: AW] = a;
  endtask

  task automatic idle(input int n);
    wr_req = 2'b00;
    rd_req = 2'b00;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    cyc = 0;
    model_reset();
    rst = 1'b0;
    wr_req = '0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    rd_req = '0; rd_addr = '0;

    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_valid1", 64'(rd_valid1), 64'(0));
    chk("rst_rd_valid3", 64'(rd_valid3), 64'(0));
    chk("rst_renb",      64'(renb1),     64'(0));
    chk("rst_wena",      64'(wena1),     64'(0));
    rst = 1'b1;
    idle(2);

    // Single write, then read from the other client
    set_wr(0, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
    step();
    set_wr(0, 1'b0, '0, '0, '0);
    set_rd(1, 1'b1, 10'h010);
    step();
    idle(4);

    // Round robin on both ports
    set_wr(0, 1'b1, 10'h001, 32'h11111111, 4'hF);
    set_wr(1, 1'b1, 10'h002, 32'h22222222, 4'hF);
    for (int i = 0; i < 4; i++) step();
    wr_req = 2'b00;
    set_rd(0, 1'b1, 10'h001);
    set_rd(1, 1'b1, 10'h002);
    for (int i = 0; i < 4; i++) step();
    idle(4);

    // Collision: client0 read blocked behind same-address write
    set_wr(0, 1'b1, 10'h3FF, 32'h12345678, 4'hF);
    set_rd(0, 1'b1, 10'h3FF);
    set_rd(1, 1'b1, 10'h000);
    step();
    wr_req = 2'b00;
    set_rd(1, 1'b0, '0);
    step();
    idle(4);

    // Byte strobes, then a zero-strobe write
    set_wr(0, 1'b1, 10'h005, 32'hAABBCCDD, 4'b0101);
    step();
    wr_req = 2'b00;
    set_rd(0, 1'b1, 10'h005);
    step();
    rd_req = 2'b00;
    set_wr(1, 1'b1, 10'h005, 32'hFFFFFFFF, 4'b0000);
    set_rd(0, 1'b1, 10'h005);
    step();
    idle(4);

    // Back-to-back reads of 10 consecutive addresses
    for (int i = 0; i < 10; i++) begin
      set_rd(0, 1'b1, 10'(32'h010 + i));
      step();
    end
    idle(5);

    // Reset with reads in flight
    set_rd(0, 1'b1, 10'h010);
    step();
    rd_req = 2'b00;
    set_rd(1, 1'b1, 10'h005);
    step();
    rd_req = 2'b00;
    rst = 1'b0;
    #1;
    chk("midrst_rd_valid1", 64'(rd_valid1), 64'(0));
    chk("midrst_rd_valid3", 64'(rd_valid3), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    idle(5);

    // Randomized traffic with proper hold-until-grant handshake
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (!wr_req[c] || last_wg[c]) begin
          if ($urandom_range(0, 9) < 7)
            set_wr(c, 1'b1, 10'($urandom_range(0, 15)), $urandom,
                   ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15)));
          else
            wr_req[c] = 1'b0;
        end
        if (!rd_req[c] || last_rg[c]) begin
          if ($urandom_range(0, 9) < 7)
            set_rd(c, 1'b1, 10'($urandom_range(0, 15)));
          else
            rd_req[c] = 1'b0;
        end
      end
      step();
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
